ps2_rx_frame: RTL

PS2_RX_FRAME -- requirements
Module: ps2_rx_frame

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_in_filter.sv | 57 +++++
 rtl/ps2_rx_frame.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: framing states, default timing constants,
// scan-code constants and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int FILTER_LEN_DEFAULT     = 8;
    localparam int TIMEOUT_CYCLES_DEFAULT = 5000;

    localparam logic [7:0] H_MAKE = 8'h33;
    localparam logic [7:0] S_MAKE = 8'h1B;
    localparam logic [7:0] D_MAKE = 8'h23;
    localparam logic [7:0] BREAK  = 8'hF0;

    // A PS/2 frame is good when data plus parity holds an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{par, data};
    endfunction

endpackage

// File: rtl/ps2_in_filter.sv
// Input conditioning for the PS/2 pins: two-flop synchronizers, a persistence
// glitch filter on the clock and a one-cycle strobe on each filtered falling edge.
module ps2_in_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEFAULT
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic PS2_CLK,
    input  logic PS2_DAT,
    output logic clk_fall,
    output logic dat_sync
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          clk_meta;
    logic          clk_sync;
    logic          dat_meta;
    logic          filt_clk;
    logic          filt_clk_d;
    logic [CW-1:0] stable_cnt;

    // Everything presets to the idle-high bus level so reset release is silent.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_meta   <= 1'b1;
            clk_sync   <= 1'b1;
            dat_meta   <= 1'b1;
            dat_sync   <= 1'b1;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
            stable_cnt <= '0;
        end else begin
            clk_meta   <= PS2_CLK;
            clk_sync   <= clk_meta;
            dat_meta   <= PS2_DAT;
            dat_sync   <= dat_meta;
            filt_clk_d <= filt_clk;
            if (clk_sync != filt_clk) begin
                if (stable_cnt == CNT_LAST) begin
                    filt_clk   <= clk_sync;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

    assign clk_fall = filt_clk_d & ~filt_clk;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 receive framer: start/8 data/parity/stop decoding with a mid-frame
// idle timeout; all result strobes are registered one cycle after the edge.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = FILTER_LEN_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] received_data,
    output logic       received_data_en,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic clk_fall;
    logic dat_sync;

    rx_state_t     state, state_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic          parity_bit, parity_next;
    logic [TW-1:0] idle_cnt, idle_next;
    logic [7:0]    data_next;
    logic          data_en_next;
    logic          parity_err_next;
    logic          frame_err_next;

    ps2_in_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_in_filter (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .PS2_CLK  (PS2_CLK),
        .PS2_DAT  (PS2_DAT),
        .clk_fall (clk_fall),
        .dat_sync (dat_sync)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state            <= IDLE;
            bit_cnt          <= '0;
            shift_reg        <= '0;
            parity_bit       <= 1'b0;
            idle_cnt         <= '0;
            received_data    <= 8'h00;
            received_data_en <= 1'b0;
            parity_err       <= 1'b0;
            frame_err        <= 1'b0;
        end else begin
            state            <= state_next;
            bit_cnt          <= bit_cnt_next;
            shift_reg        <= shift_next;
            parity_bit       <= parity_next;
            idle_cnt         <= idle_next;
            received_data    <= data_next;
            received_data_en <= data_en_next;
            parity_err       <= parity_err_next;
            frame_err        <= frame_err_next;
        end
    end

    // A fall strobe always wins over the timeout, since it restarts the idle count.
    always_comb begin
        state_next      = state;
        bit_cnt_next    = bit_cnt;
        shift_next      = shift_reg;
        parity_next     = parity_bit;
        idle_next       = '0;
        data_next       = received_data;
        data_en_next    = 1'b0;
        parity_err_next = 1'b0;
        frame_err_next  = 1'b0;

        if (clk_fall) begin
            unique case (state)
                IDLE: begin
                    if (!dat_sync) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
                DATA: begin
                    shift_next   = {dat_sync, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    parity_next = dat_sync;
                    state_next  = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if (!dat_sync) begin
                        frame_err_next = 1'b1;
                    end else if (odd_parity_ok(shift_reg, parity_bit)) begin
                        data_next    = shift_reg;
                        data_en_next = 1'b1;
                    end else begin
                        parity_err_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (idle_cnt == TIMEOUT_LAST) begin
                state_next     = IDLE;
                bit_cnt_next   = '0;
                shift_next     = '0;
                frame_err_next = 1'b1;
            end else begin
                idle_next = idle_cnt + 1'b1;
            end
        end
    end

endmodule
